// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_unit_pkg;

    localparam int unsigned FETCH_XLEN = 64;
    localparam logic [FETCH_XLEN-1:0] RESET_PC_DEFAULT = 64'h8000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Fetch FSM state encoding
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t IDLE = 2'd0;  // nothing outstanding
    localparam fetch_state_t WAIT = 2'd1;  // request outstanding
    localparam fetch_state_t DROP = 2'd2;  // outstanding request is stale

    typedef struct packed {
        logic [31:0]           instr;
        logic [FETCH_XLEN-1:0] pc;
    } fetch_entry_t;

    // Instructions are word aligned; low address bits are forced to zero.
    function automatic logic [FETCH_XLEN-1:0] align_pc(input logic [FETCH_XLEN-1:0] pc);
        return pc & ~{{(FETCH_XLEN-2){1'b0}}, 2'b11};
    endfunction

endpackage

// File: rtl/ifetch_unit_fetch_fifo.sv
// Small FIFO of fetched (instr, pc) entries; flush beats push and pop.
module ifetch_unit_fetch_fifo
    import ifetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  wdata,
    output fetch_entry_t  rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && !empty;

    // Pointer and occupancy update; a flush empties the buffer outright.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only visible while counted as valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= wdata;
    end

    assign rdata = mem[rptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, instruction bus requests, redirect and stale-response handling.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] drop_addr_q, drop_addr_d;
    logic            issue, push, pop, full, empty, room;
    logic [CW-1:0]   count, count_after;
    fetch_entry_t    head, wdata;

    ifetch_unit_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wdata),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // A request from IDLE is only made when a slot is free, so no response can be lost.
    assign issue = (state_q == IDLE) ? (!full && !redirect_valid) : 1'b1;
    assign pop   = instr_valid && instr_ready;
    assign wdata = '{instr: imem_resp_data, pc: pc_q};

    // Occupancy once this cycle's response is pushed, deciding whether to keep requesting.
    always_comb begin
        count_after = count + CW'(1) - CW'(pop);
        room        = (count_after < CW'(DEPTH));
    end

    // Next-state, pc and push control; a redirect overrides everything else.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        push        = 1'b0;
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
            if (state_q == WAIT && !imem_resp_valid) begin
                state_d     = DROP;
                drop_addr_d = pc_q;
            end else if (state_q == DROP && !imem_resp_valid) begin
                state_d = DROP;
            end else begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE, WAIT: begin
                    if (issue && imem_resp_valid) begin
                        push    = 1'b1;
                        pc_d    = pc_q + XLEN'(4);
                        state_d = room ? WAIT : IDLE;
                    end else if (issue) begin
                        state_d = WAIT;
                    end
                end
                DROP:    if (imem_resp_valid) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            drop_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    // While stale, the bus still sees the original address until its response returns.
    assign imem_req_valid = issue && !reset;
    assign imem_req_addr  = (state_q == DROP) ? drop_addr_q : pc_q;

    assign instr_valid = !empty;
    assign instr       = empty ? NOP_INSTR : head.instr;
    assign instr_pc    = empty ? '0 : head.pc;

    logic            chk_out_q;
    logic [XLEN-1:0] chk_addr_q;

    // Protocol checks: held request, no overflowing push, no unsolicited response.
    always_ff @(posedge clk) begin
        chk_addr_q <= imem_req_addr;
        if (reset) begin
            chk_out_q <= 1'b0;
        end else begin
            chk_out_q <= imem_req_valid && !imem_resp_valid;
            if (chk_out_q) assert (imem_req_valid && imem_req_addr == chk_addr_q);
            assert (!(push && full && !pop));
            assert (!imem_resp_valid || imem_req_valid);
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a programmable-latency instruction bus model.
module tb_ifetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int compared   = 0;
    int mismatched = 0;
    int lat;
    int wait_cnt;

    ifetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus model: respond once a request has been outstanding for 'lat' cycles (0 = same cycle).
    always_comb begin
        imem_resp_valid = 1'b0;
        if (!reset && imem_req_valid) imem_resp_valid = (wait_cnt >= lat);
    end
    assign imem_resp_data = imem_req_addr[31:0] ^ 32'hFFFF_0000;

    always @(posedge clk) begin
        if (reset || !imem_req_valid || imem_resp_valid) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; lat = 0;
        tick(); tick();
        @(negedge clk);
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_instr_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr", 64'(instr), 64'h13);
        chk("rst_instr_pc", instr_pc, 64'd0);
        tick();

        // 1: zero-latency streaming
        reset = 1'b0;                                   // C1
        @(negedge clk);
        chk("t1_req_valid", 64'(imem_req_valid), 64'd1);
        chk("t1_addr0", imem_req_addr, 64'h8000_0000);
        chk("t1_ivalid0", 64'(instr_valid), 64'd0);
        tick();                                         // C2
        @(negedge clk);
        chk("t1_addr1", imem_req_addr, 64'h8000_0004);
        chk("t1_pc0", instr_pc, 64'h8000_0000);
        chk("t1_instr0", 64'(instr), 64'h7FFF_0000);
        chk("t1_ivalid1", 64'(instr_valid), 64'd1);
        tick();                                         // C3
        @(negedge clk);
        chk("t1_addr2", imem_req_addr, 64'h8000_0008);
        chk("t1_pc1", instr_pc, 64'h8000_0004);
        tick();                                         // C4

        // 2: back-pressure fills both entries
        instr_ready = 1'b0;
        @(negedge clk);
        chk("t2_head", instr_pc, 64'h8000_0008);
        tick();                                         // C5
        for (int i = 0; i < 4; i++) begin               // C5..C8
            @(negedge clk);
            chk("t2_req_stall", 64'(imem_req_valid), 64'd0);
            chk("t2_head_hold", instr_pc, 64'h8000_0008);
            tick();
        end
        instr_ready = 1'b1;                             // C9
        @(negedge clk);
        chk("t2_req_full", 64'(imem_req_valid), 64'd0);
        chk("t2_head_rel", instr_pc, 64'h8000_0008);
        tick();                                         // C10
        @(negedge clk);
        chk("t2_second", instr_pc, 64'h8000_000C);
        chk("t2_req_resume", 64'(imem_req_valid), 64'd1);
        chk("t2_addr_resume", imem_req_addr, 64'h8000_0010);
        tick();                                         // C11

        // 3: redirect while a slow request is outstanding
        lat = 3;
        @(negedge clk);
        chk("t2_third", instr_pc, 64'h8000_0010);
        chk("t3_addr_old", imem_req_addr, 64'h8000_0014);
        tick();                                         // C12
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
        @(negedge clk);
        chk("t3_empty", 64'(instr_valid), 64'd0);
        tick();                                         // C13
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t3_drop_req", 64'(imem_req_valid), 64'd1);
        chk("t3_drop_addr", imem_req_addr, 64'h8000_0014);
        tick();                                         // C14, stale response
        @(negedge clk);
        chk("t3_drop_addr2", imem_req_addr, 64'h8000_0014);
        tick();                                         // C15
        @(negedge clk);
        chk("t3_new_addr", imem_req_addr, 64'h8000_0100);
        chk("t3_stale_gone", 64'(instr_valid), 64'd0);
        tick(); tick(); tick();                         // C18 response
        tick();                                         // C19
        lat = 0;
        @(negedge clk);
        chk("t3_first_valid", 64'(instr_valid), 64'd1);
        chk("t3_first_pc", instr_pc, 64'h8000_0100);
        chk("t3_first_instr", 64'(instr), 64'h7FFF_0100);
        tick();                                         // C20

        // 4: redirect with simultaneous response and pop
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0042;
        @(negedge clk);
        chk("t4_head", instr_pc, 64'h8000_0104);
        tick();                                         // C21
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t4_flushed", 64'(instr_valid), 64'd0);
        chk("t4_addr", imem_req_addr, 64'h8000_0040);
        chk("t4_req", 64'(imem_req_valid), 64'd1);
        tick();                                         // C22

        // 5: two redirects while stale
        lat = 3; redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
        @(negedge clk);
        chk("t4_pc", instr_pc, 64'h8000_0040);
        chk("t4_instr", 64'(instr), 64'h7FFF_0040);
        tick();                                         // C23
        redirect_pc = 64'h8000_0300;
        @(negedge clk);
        chk("t5_drop_addr", imem_req_addr, 64'h8000_0044);
        chk("t5_empty", 64'(instr_valid), 64'd0);
        tick();                                         // C24
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t5_drop_hold", imem_req_addr, 64'h8000_0044);
        tick();                                         // C25, stale response
        tick();                                         // C26
        @(negedge clk);
        chk("t5_addr", imem_req_addr, 64'h8000_0300);
        chk("t5_empty2", 64'(instr_valid), 64'd0);
        tick(); tick(); tick();                         // C29 response
        tick();                                         // C30

        // 6: pc wrap, then reset while waiting
        lat = 0; redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        chk("t5_pc", instr_pc, 64'h8000_0300);
        chk("t5_instr", 64'(instr), 64'h7FFF_0300);
        tick();                                         // C31
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t6_addr_top", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t6_empty", 64'(instr_valid), 64'd0);
        tick();                                         // C32
        lat = 3;
        @(negedge clk);
        chk("t6_wrap_addr", imem_req_addr, 64'd0);
        chk("t6_top_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t6_top_instr", 64'(instr), 64'h0000_FFFC);
        tick();                                         // C33
        reset = 1'b1;
        tick();                                         // C34
        @(negedge clk);
        chk("t6_rst_req", 64'(imem_req_valid), 64'd0);
        chk("t6_rst_ivalid", 64'(instr_valid), 64'd0);
        chk("t6_rst_instr", 64'(instr), 64'h13);
        chk("t6_rst_pc", instr_pc, 64'd0);
        tick();                                         // C35
        reset = 1'b0; lat = 0;
        @(negedge clk);
        chk("t6_restart_req", 64'(imem_req_valid), 64'd1);
        chk("t6_restart_addr", imem_req_addr, 64'h8000_0000);
        tick();
        @(negedge clk);
        chk("t6_restart_pc", instr_pc, 64'h8000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
